alu_issue: RTL and testbench

- Issue/hazard stage directly upstream of the DSP48E2-based ALU in each PE.
- Accepts a 3-bit opcode instruction stream over valid/ready and checks register hazards with a per-register pending scoreboard.
- For each issued instruction it drives registered operand read addresses and DSP control words (OPMODE, ALUMODE, INMODE, USEMULT, CEA2/CEB2).
- It delays the destination tag by a fixed latency to produce regfile writeback strobes.

---
 rtl/alu_issue_pkg.sv | 56 +++++
 rtl/alu_issue_tagpipe.sv | 43 ++++
 rtl/alu_issue.sv | 127 ++++++++++++
 tb/tb_alu_issue.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared encodings for the ALU issue stage.
//   - 3-bit instruction opcodes
//   - DSP48E2 OPMODE / ALUMODE / INMODE control constants
//   - decode_op(): opcode -> control word and source-usage mask
package alu_issue_pkg;

   typedef enum logic [2:0] {
      OP_NOP    = 3'b000,
      OP_ADD    = 3'b001,
      OP_SUB    = 3'b010,
      OP_MUL    = 3'b011,
      OP_MULADD = 3'b100,
      OP_MAC    = 3'b101,
      OP_PASSC  = 3'b110,
      OP_ILL    = 3'b111
   } op_e;

   localparam logic [6:0] OPM_AB_C = 7'b0110011;  // P = A:B + C
   localparam logic [6:0] OPM_M    = 7'b0000101;  // P = M
   localparam logic [6:0] OPM_M_C  = 7'b0110101;  // P = M + C
   localparam logic [6:0] OPM_M_P  = 7'b0100101;  // P = M + P (accumulate)
   localparam logic [6:0] OPM_C    = 7'b0110000;  // P = C
   localparam logic [6:0] OPM_HOLD = 7'b0100000;  // P = P, keeps the accumulator across bubbles

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_ZSUB = 4'b0011;

   localparam logic [4:0] INMODE_A2B2 = 5'b00000;

   typedef struct packed {
      logic [6:0] opmode;
      logic [3:0] alumode;
      logic       usemult;
      logic       use_a;
      logic       use_b;
      logic       use_c;
      logic       is_nop;   // NOP or illegal: never stalls, never issues
   } dec_t;

   function automatic dec_t decode_op(input logic [2:0] op);
      dec_t d;
      d = '{opmode: OPM_HOLD, alumode: ALU_ADD, usemult: 1'b0,
            use_a: 1'b0, use_b: 1'b0, use_c: 1'b0, is_nop: 1'b1};
      case (op_e'(op))
         OP_ADD:    d = '{OPM_AB_C, ALU_ADD,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
         OP_SUB:    d = '{OPM_AB_C, ALU_ZSUB, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
         OP_MUL:    d = '{OPM_M,    ALU_ADD,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
         OP_MULADD: d = '{OPM_M_C,  ALU_ADD,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
         OP_MAC:    d = '{OPM_M_P,  ALU_ADD,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
         OP_PASSC:  d = '{OPM_C,    ALU_ADD,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
         default:   ;  // OP_NOP, OP_ILL keep the hold default
      endcase
      return d;
   endfunction

endpackage

// File: rtl/alu_issue_tagpipe.sv
// alu_issue_tagpipe: LAT-deep delay line of {valid, addr} with async clear.
//   clk, rst        : clock, asynchronous active-high clear
//   in_valid_i/addr : tag entering at the issue handshake
//   out_valid_o/addr: the same tag LAT cycles after the handshake
// LAT must be at least 2.
module alu_issue_tagpipe #(
   parameter int LAT = 6,
   parameter int AW  = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid_i,
   input  logic [AW-1:0] in_addr_i,
   output logic          out_valid_o,
   output logic [AW-1:0] out_addr_o
);

   logic [LAT-1:0] valid_q, valid_d;
   logic [AW-1:0]  addr_q [LAT];
   logic [AW-1:0]  addr_d [LAT];

   always_comb begin
      valid_d   = {valid_q[LAT-2:0], in_valid_i};
      addr_d[0] = in_addr_i;
      for (int i = 1; i < LAT; i++) addr_d[i] = addr_q[i-1];
   end

   // NOTE: the address stages are cleared too, not just the valid bits, so
   // wb_addr_o reads zero after reset instead of stale in-flight addresses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < LAT; i++) addr_q[i] <= '0;
      end else begin
         valid_q <= valid_d;
         for (int i = 0; i < LAT; i++) addr_q[i] <= addr_d[i];
      end
   end

   assign out_valid_o = valid_q[LAT-1];
   assign out_addr_o  = addr_q[LAT-1];

endmodule

// File: rtl/alu_issue.sv
// alu_issue: issue/hazard stage in front of the DSP48E2 ALU of a PE.
//   instr_*      : valid/ready instruction stream (opcode, wb flag, rd, rsa/rsb/rsc)
//   ra_*_o       : registered regfile read addresses for A/B/C
//   opmode_o, alumode_o, inmode_o, usemult_o, cea2_o, ceb2_o : registered DSP controls
//   wb_valid_o, wb_addr_o : regfile write strobe, LAT cycles after issue
//   busy_o       : some register still has a result in flight
//   illegal_o    : one-cycle pulse when opcode 111 is accepted
module alu_issue
   import alu_issue_pkg::*;
#(
   parameter int NREG = 32,
   parameter int RA_W = 5,
   parameter int LAT  = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            instr_valid_i,
   output logic            instr_ready_o,
   input  logic [2:0]      instr_op_i,
   input  logic            instr_wb_i,
   input  logic [RA_W-1:0] instr_rd_i,
   input  logic [RA_W-1:0] instr_rsa_i,
   input  logic [RA_W-1:0] instr_rsb_i,
   input  logic [RA_W-1:0] instr_rsc_i,
   output logic [RA_W-1:0] ra_a_o,
   output logic [RA_W-1:0] ra_b_o,
   output logic [RA_W-1:0] ra_c_o,
   output logic [6:0]      opmode_o,
   output logic [3:0]      alumode_o,
   output logic [4:0]      inmode_o,
   output logic            usemult_o,
   output logic            cea2_o,
   output logic            ceb2_o,
   output logic            wb_valid_o,
   output logic [RA_W-1:0] wb_addr_o,
   output logic            busy_o,
   output logic            illegal_o
);

   dec_t            dec;
   logic            hazard, fire, issue, set_pend;
   logic [NREG-1:0] pending_q, pending_d;
   logic [RA_W-1:0] ra_a_q, ra_a_d, ra_b_q, ra_b_d, ra_c_q, ra_c_d;
   logic [6:0]      opmode_q, opmode_d;
   logic [3:0]      alumode_q, alumode_d;
   logic            usemult_q, usemult_d, ce_q, ce_d, illegal_q, illegal_d;

   // NOTE: every signal gets a default at the top of the block so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      dec = decode_op(instr_op_i);

      // Pending bits being cleared this cycle still stall: no bypass.
      hazard = !dec.is_nop &&
               ((dec.use_a && pending_q[instr_rsa_i]) ||
                (dec.use_b && pending_q[instr_rsb_i]) ||
                (dec.use_c && pending_q[instr_rsc_i]) ||
                (instr_wb_i && pending_q[instr_rd_i]));

      fire     = instr_valid_i && !hazard;
      issue    = fire && !dec.is_nop;
      set_pend = issue && instr_wb_i;

      // WAW stalls guarantee the set and clear never hit the same bit.
      pending_d = pending_q;
      if (wb_valid_o) pending_d[wb_addr_o] = 1'b0;
      if (set_pend)   pending_d[instr_rd_i] = 1'b1;

      ra_a_d    = issue ? instr_rsa_i : ra_a_q;
      ra_b_d    = issue ? instr_rsb_i : ra_b_q;
      ra_c_d    = issue ? instr_rsc_i : ra_c_q;
      opmode_d  = issue ? dec.opmode  : OPM_HOLD;
      alumode_d = issue ? dec.alumode : ALU_ADD;
      usemult_d = issue && dec.usemult;
      ce_d      = issue;
      illegal_d = fire && (op_e'(instr_op_i) == OP_ILL);
   end

   // NOTE: state is updated with non-blocking assignments only, so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= '0;
         ra_a_q    <= '0;
         ra_b_q    <= '0;
         ra_c_q    <= '0;
         opmode_q  <= '0;
         alumode_q <= '0;
         usemult_q <= 1'b0;
         ce_q      <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         pending_q <= pending_d;
         ra_a_q    <= ra_a_d;
         ra_b_q    <= ra_b_d;
         ra_c_q    <= ra_c_d;
         opmode_q  <= opmode_d;
         alumode_q <= alumode_d;
         usemult_q <= usemult_d;
         ce_q      <= ce_d;
         illegal_q <= illegal_d;
      end
   end

   alu_issue_tagpipe #(.LAT(LAT), .AW(RA_W)) u_tagpipe (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (set_pend),
      .in_addr_i   (instr_rd_i),
      .out_valid_o (wb_valid_o),
      .out_addr_o  (wb_addr_o)
   );

   assign instr_ready_o = !hazard;
   assign ra_a_o        = ra_a_q;
   assign ra_b_o        = ra_b_q;
   assign ra_c_o        = ra_c_q;
   assign opmode_o      = opmode_q;
   assign alumode_o     = alumode_q;
   assign inmode_o      = INMODE_A2B2;
   assign usemult_o     = usemult_q;
   assign cea2_o        = ce_q;
   assign ceb2_o        = ce_q;
   assign busy_o        = |pending_q;
   assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: self-checking bench for alu_issue (table vectors + writeback scoreboard).
module tb_alu_issue;

   localparam int LAT = 6;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       instr_valid_i = 1'b0;
   logic       instr_ready_o;
   logic [2:0] instr_op_i = '0;
   logic       instr_wb_i = 1'b0;
   logic [4:0] instr_rd_i = '0, instr_rsa_i = '0, instr_rsb_i = '0, instr_rsc_i = '0;
   logic [4:0] ra_a_o, ra_b_o, ra_c_o;
   logic [6:0] opmode_o;
   logic [3:0] alumode_o;
   logic [4:0] inmode_o;
   logic       usemult_o, cea2_o, ceb2_o, wb_valid_o, busy_o, illegal_o;
   logic [4:0] wb_addr_o;

   alu_issue #(.NREG(32), .RA_W(5), .LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
      .instr_op_i(instr_op_i), .instr_wb_i(instr_wb_i), .instr_rd_i(instr_rd_i),
      .instr_rsa_i(instr_rsa_i), .instr_rsb_i(instr_rsb_i), .instr_rsc_i(instr_rsc_i),
      .ra_a_o(ra_a_o), .ra_b_o(ra_b_o), .ra_c_o(ra_c_o),
      .opmode_o(opmode_o), .alumode_o(alumode_o), .inmode_o(inmode_o),
      .usemult_o(usemult_o), .cea2_o(cea2_o), .ceb2_o(ceb2_o),
      .wb_valid_o(wb_valid_o), .wb_addr_o(wb_addr_o),
      .busy_o(busy_o), .illegal_o(illegal_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Writeback scoreboard: expected {rd, cycle} pushed at issue, popped on wb_valid_o.
   typedef struct {
      logic [4:0] rd;
      int         due;
   } exp_wb_t;
   exp_wb_t sb[$];

   always @(negedge clk) begin
      if (!rst) begin
         if (wb_valid_o) begin
            if (sb.size() == 0) check("wb_unexpected", wb_valid_o, 1'b0);
            else begin
               exp_wb_t e;
               e = sb.pop_front();
               check("wb_addr", wb_addr_o, e.rd);
               check("wb_cycle", cyc, e.due);
            end
         end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            check("wb_missing", wb_valid_o, 1'b1);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   logic last_ready;

   task automatic drive(input logic [2:0] op, input logic wb, input logic [4:0] rd,
                        input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
      instr_valid_i = 1'b1;
      instr_op_i    = op;
      instr_wb_i    = wb;
      instr_rd_i    = rd;
      instr_rsa_i   = a;
      instr_rsb_i   = b;
      instr_rsc_i   = c;
   endtask

   task automatic idle();
      instr_valid_i = 1'b0;
      instr_op_i    = 3'b000;
      instr_wb_i    = 1'b0;
   endtask

   // One clock: sample ready before the edge, return #1 after the edge.
   task automatic tick();
      logic push;
      logic [4:0] rd;
      #1;
      last_ready = instr_ready_o;
      push = instr_valid_i && instr_ready_o && instr_wb_i &&
             instr_op_i != 3'b000 && instr_op_i != 3'b111;
      rd = instr_rd_i;
      @(posedge clk);
      #1;
      if (push) sb.push_back('{rd: rd, due: cyc + LAT - 1});
   endtask

   task automatic check_hold(input string tag);
      check({tag, "_opmode_hold"}, opmode_o, 7'b0100000);
      check({tag, "_alumode_hold"}, alumode_o, 4'b0000);
      check({tag, "_cea2_off"}, cea2_o, 1'b0);
      check({tag, "_ceb2_off"}, ceb2_o, 1'b0);
      check({tag, "_usemult_off"}, usemult_o, 1'b0);
   endtask

   // ADD rd=3 from an idle, empty scoreboard; busy window t+1..t+6.
   task automatic scen_add(input string tag);
      drive(3'b001, 1'b1, 5'd3, 5'd1, 5'd2, 5'd4);
      tick();
      check({tag, "_ready"}, last_ready, 1'b1);
      check({tag, "_opmode"}, opmode_o, 7'b0110011);
      check({tag, "_alumode"}, alumode_o, 4'b0000);
      check({tag, "_cea2"}, cea2_o, 1'b1);
      check({tag, "_ceb2"}, ceb2_o, 1'b1);
      check({tag, "_ra_a"}, ra_a_o, 5'd1);
      check({tag, "_inmode"}, inmode_o, 5'd0);
      check({tag, "_busy_t1"}, busy_o, 1'b1);
      idle();
      for (int k = 1; k <= 6; k++) begin
         tick();
         check({tag, "_busy_window"}, busy_o, (1 + k <= 6) ? 1'b1 : 1'b0);
      end
   endtask

   typedef struct {
      logic [2:0] op;
      logic       wb;
      logic [4:0] rd, a, b, c;
      logic [6:0] opm;
      logic [3:0] alu;
      logic       um, ce, ill;
      logic [4:0] ra_a, ra_c;
   } vec_t;

   vec_t vecs[9];

   initial begin
      vecs[0] = '{3'b001, 1'b0, 5'd0,  5'd1, 5'd2, 5'd4,   7'b0110011, 4'b0000, 1'b0, 1'b1, 1'b0, 5'd1,  5'd4};
      vecs[1] = '{3'b010, 1'b0, 5'd0,  5'd9, 5'd10, 5'd11, 7'b0110011, 4'b0011, 1'b0, 1'b1, 1'b0, 5'd9,  5'd11};
      vecs[2] = '{3'b011, 1'b0, 5'd0,  5'd12, 5'd13, 5'd1, 7'b0000101, 4'b0000, 1'b1, 1'b1, 1'b0, 5'd12, 5'd1};
      vecs[3] = '{3'b100, 1'b0, 5'd0,  5'd13, 5'd2, 5'd3,  7'b0110101, 4'b0000, 1'b1, 1'b1, 1'b0, 5'd13, 5'd3};
      vecs[4] = '{3'b101, 1'b0, 5'd0,  5'd14, 5'd2, 5'd6,  7'b0100101, 4'b0000, 1'b1, 1'b1, 1'b0, 5'd14, 5'd6};
      vecs[5] = '{3'b110, 1'b0, 5'd0,  5'd15, 5'd2, 5'd16, 7'b0110000, 4'b0000, 1'b0, 1'b1, 1'b0, 5'd15, 5'd16};
      vecs[6] = '{3'b000, 1'b1, 5'd9,  5'd17, 5'd2, 5'd18, 7'b0100000, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd15, 5'd16};
      vecs[7] = '{3'b111, 1'b1, 5'd9,  5'd18, 5'd2, 5'd19, 7'b0100000, 4'b0000, 1'b0, 1'b0, 1'b1, 5'd15, 5'd16};
      vecs[8] = '{3'b001, 1'b0, 5'd0,  5'd19, 5'd2, 5'd20, 7'b0110011, 4'b0000, 1'b0, 1'b1, 1'b0, 5'd19, 5'd20};

      // Reset state
      #12;
      check("rst_opmode", opmode_o, 7'd0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_wb_valid", wb_valid_o, 1'b0);
      check("rst_cea2", cea2_o, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      idle();
      tick();
      check_hold("post_rst");

      scen_add("add1");

      // Table: every opcode, back to back, no write-back hazards
      foreach (vecs[i]) begin
         drive(vecs[i].op, vecs[i].wb, vecs[i].rd, vecs[i].a, vecs[i].b, vecs[i].c);
         tick();
         check($sformatf("vec%0d_ready", i), last_ready, 1'b1);
         check($sformatf("vec%0d_opmode", i), opmode_o, vecs[i].opm);
         check($sformatf("vec%0d_alumode", i), alumode_o, vecs[i].alu);
         check($sformatf("vec%0d_usemult", i), usemult_o, vecs[i].um);
         check($sformatf("vec%0d_cea2", i), cea2_o, vecs[i].ce);
         check($sformatf("vec%0d_ceb2", i), ceb2_o, vecs[i].ce);
         check($sformatf("vec%0d_illegal", i), illegal_o, vecs[i].ill);
         check($sformatf("vec%0d_ra_a", i), ra_a_o, vecs[i].ra_a);
         check($sformatf("vec%0d_ra_c", i), ra_c_o, vecs[i].ra_c);
         check($sformatf("vec%0d_busy", i), busy_o, 1'b0);
      end
      idle();
      tick();

      // RAW stall on rsc through the clear cycle, WAW stall, NOP never stalls
      drive(3'b001, 1'b1, 5'd5, 5'd1, 5'd2, 5'd3);
      tick();
      check("raw_add_ready", last_ready, 1'b1);
      drive(3'b001, 1'b1, 5'd5, 5'd10, 5'd11, 5'd12);
      tick();
      check("waw_ready", last_ready, 1'b0);
      check("waw_no_ce", cea2_o, 1'b0);
      drive(3'b000, 1'b1, 5'd5, 5'd5, 5'd5, 5'd5);
      tick();
      check("nop_ready", last_ready, 1'b1);
      drive(3'b010, 1'b0, 5'd0, 5'd6, 5'd7, 5'd5);
      for (int k = 3; k <= 6; k++) begin
         tick();
         check($sformatf("raw_stall_t%0d", k), last_ready, 1'b0);
      end
      tick();
      check("raw_sub_ready_t7", last_ready, 1'b1);
      check("sub_alumode", alumode_o, 4'b0011);
      check("sub_opmode", opmode_o, 7'b0110011);
      check("sub_ra_c", ra_c_o, 5'd5);
      idle();
      tick();

      // MUL then four back-to-back MACs, last one writes r8
      drive(3'b011, 1'b0, 5'd7, 5'd1, 5'd2, 5'd0);
      tick();
      check("mul_ready", last_ready, 1'b1);
      check("mul_opmode", opmode_o, 7'b0000101);
      check("mul_usemult", usemult_o, 1'b1);
      for (int k = 0; k < 4; k++) begin
         drive(3'b101, (k == 3), (k == 3) ? 5'd8 : 5'd0, 5'd1, 5'd2, 5'd0);
         tick();
         check($sformatf("mac%0d_ready", k), last_ready, 1'b1);
         check($sformatf("mac%0d_opmode", k), opmode_o, 7'b0100101);
         check($sformatf("mac%0d_usemult", k), usemult_o, 1'b1);
      end
      idle();
      for (int k = 0; k < 7; k++) tick();

      // Idle gap between two MACs keeps P
      drive(3'b101, 1'b0, 5'd0, 5'd1, 5'd2, 5'd0);
      tick();
      idle();
      tick();
      check_hold("mac_gap");
      drive(3'b101, 1'b0, 5'd0, 5'd1, 5'd2, 5'd0);
      tick();
      check("mac_after_gap", opmode_o, 7'b0100101);
      idle();
      tick();

      // Reset with three results in flight
      for (int k = 0; k < 3; k++) begin
         drive(3'b001, 1'b1, 5'd20 + 5'(k), 5'd0, 5'd0, 5'd0);
         tick();
      end
      idle();
      #3;
      rst = 1'b1;
      sb.delete();
      #1;
      check("mid_rst_opmode", opmode_o, 7'd0);
      check("mid_rst_busy", busy_o, 1'b0);
      check("mid_rst_ra_a", ra_a_o, 5'd0);
      check("mid_rst_cea2", cea2_o, 1'b0);
      check("mid_rst_wb_addr", wb_addr_o, 5'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      check_hold("rst2");
      for (int k = 0; k < 8; k++) begin
         tick();
         check("post_rst_no_wb", wb_valid_o, 1'b0);
         check("post_rst_busy", busy_o, 1'b0);
      end

      scen_add("add2");

      for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
      check("sb_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
